// File: rtl/qsys_block_nios2e_dct_pkg.sv
// Shared definitions for the DCT trace packer: FSM states, default geometry, slot addressing.
// Frame geometry defaults: 15 slots of 2-bit codes packed LSB-first into a 30-bit payload.
package qsys_block_nios2e_dct_pkg;

    localparam int CODE_W = 2;
    localparam int SLOTS  = 15;
    localparam int BUF_W  = CODE_W * SLOTS;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        HOLD  = 2'd1,
        ENDED = 2'd2
    } dct_state_t;

    // Lowest bit of slot i within the packed payload.
    function automatic int slot_lo(input int i);
        return CODE_W * i;
    endfunction

endpackage

// File: rtl/qsys_block_nios2e_dct_slot_writer.sv
// Frame buffer plus slot count: writes a code into slot[count] and bumps count, or clears both.
// Single-cycle update; no backpressure of its own, the owning FSM gates wr/clr.
module qsys_block_nios2e_dct_slot_writer
    import qsys_block_nios2e_dct_pkg::*;
#(
    parameter int CODE_W = qsys_block_nios2e_dct_pkg::CODE_W,
    parameter int SLOTS  = qsys_block_nios2e_dct_pkg::SLOTS,
    parameter int BUF_W  = qsys_block_nios2e_dct_pkg::BUF_W,
    parameter int CNT_W  = qsys_block_nios2e_dct_pkg::CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr,
    input  logic [CODE_W-1:0] wr_data,
    input  logic              clr,
    output logic [BUF_W-1:0]  buffer,
    output logic [CNT_W-1:0]  count
);

    // slot_lo() is bound to the package code width, so the two must agree.
    if (CODE_W != qsys_block_nios2e_dct_pkg::CODE_W) begin : g_code_w_check
        $error("slot writer CODE_W must match package CODE_W");
    end

    logic [BUF_W-1:0] buffer_next;

    always_comb begin
        buffer_next = buffer;
        for (int i = 0; i < SLOTS; i++) begin
            if (count == CNT_W'(i)) begin
                buffer_next[slot_lo(i) +: CODE_W] = wr_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            buffer <= '0;
            count  <= '0;
        end else if (clr) begin
            buffer <= '0;
            count  <= '0;
        end else if (wr) begin
            buffer <= buffer_next;
            count  <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/qsys_block_nios2e_dct_packer.sv
// Packs 2-bit trace codes into 15-slot frames and sequences the end-of-test flush/drain.
// Frame valid one cycle after the filling accept; code_ready drops while a frame is held or after flush.
module qsys_block_nios2e_dct_packer
    import qsys_block_nios2e_dct_pkg::*;
#(
    parameter int CODE_W = qsys_block_nios2e_dct_pkg::CODE_W,
    parameter int SLOTS  = qsys_block_nios2e_dct_pkg::SLOTS,
    parameter int BUF_W  = qsys_block_nios2e_dct_pkg::BUF_W,
    parameter int CNT_W  = qsys_block_nios2e_dct_pkg::CNT_W,
    parameter int FCNT_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              code_valid,
    input  logic [CODE_W-1:0] code_data,
    output logic              code_ready,
    input  logic              flush_req,
    output logic              frame_valid,
    input  logic              frame_ready,
    output logic [BUF_W-1:0]  dct_buffer,
    output logic [CNT_W-1:0]  dct_count,
    output logic              test_ending,
    output logic              test_has_ended,
    output logic [FCNT_W-1:0] frames_sent
);

    if (BUF_W != CODE_W * SLOTS) begin : g_buf_w_check
        $error("BUF_W must equal CODE_W*SLOTS");
    end
    if ((2 ** CNT_W) <= SLOTS) begin : g_cnt_w_check
        $error("CNT_W too narrow for SLOTS");
    end

    dct_state_t       state, state_next;
    logic             flush_latched;
    logic             accept, handshake, clr, set_flush;
    logic [CNT_W-1:0] count_after;

    always_comb begin
        state_next  = state;
        code_ready  = (state == FILL) && !flush_latched;
        accept      = code_valid && code_ready;
        handshake   = frame_valid && frame_ready;
        clr         = 1'b0;
        set_flush   = 1'b0;
        count_after = dct_count + CNT_W'(accept);
        case (state)
            FILL: begin
                // A same-cycle code is already folded into count_after, so it joins the flushed frame.
                if (flush_req) begin
                    set_flush  = 1'b1;
                    state_next = (count_after != '0) ? HOLD : ENDED;
                end else if (count_after == CNT_W'(SLOTS)) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                set_flush = flush_req;
                if (handshake) begin
                    clr        = 1'b1;
                    state_next = (flush_latched || flush_req) ? ENDED : FILL;
                end
            end
            ENDED:   state_next = ENDED;
            default: state_next = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= FILL;
            flush_latched  <= 1'b0;
            frame_valid    <= 1'b0;
            test_ending    <= 1'b0;
            test_has_ended <= 1'b0;
            frames_sent    <= '0;
        end else begin
            state       <= state_next;
            frame_valid <= (state_next == HOLD);
            if (set_flush) begin
                flush_latched <= 1'b1;
            end
            // test_ending hands over to test_has_ended on the first ENDED cycle, never overlapping.
            if (state == ENDED) begin
                test_ending    <= 1'b0;
                test_has_ended <= 1'b1;
            end else if (set_flush) begin
                test_ending <= 1'b1;
            end
            if (handshake && (frames_sent != '1)) begin
                frames_sent <= frames_sent + FCNT_W'(1);
            end
        end
    end

    qsys_block_nios2e_dct_slot_writer #(
        .CODE_W (CODE_W),
        .SLOTS  (SLOTS),
        .BUF_W  (BUF_W),
        .CNT_W  (CNT_W)
    ) u_slot_writer (
        .clk     (clk),
        .reset   (reset),
        .wr      (accept),
        .wr_data (code_data),
        .clr     (clr),
        .buffer  (dct_buffer),
        .count   (dct_count)
    );

endmodule
